// File: rtl/ram_bus_initiator.sv
// Fabric-side APB-style initiator for the DMMainPorts RamBus register port.
// Single outstanding transaction, ready/valid command/response channels, ACCESS-phase timeout.
module ram_bus_initiator #(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic              clk,
  input  logic              DEVRST_N,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic              CmdWrnRd,
  input  logic [ADDR_W-1:0] CmdAddress,
  input  logic [DATA_W-1:0] CmdData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspTimeout,
  output logic              RamBusnCs,
  output logic              RamBusLatch,
  output logic              RamBusWrnRd,
  output logic [ADDR_W-1:0] RamBusAddress,
  output logic [DATA_W-1:0] RamBusDataIn,
  input  logic              RamBusAck,
  input  logic [DATA_W-1:0] RamBusDataOut
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                ncs_q, ncs_d;
  logic                latch_q, latch_d;
  logic                wrnrd_q, wrnrd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_hit;

  // A zero TIMEOUT_CYCLES disables the abort path entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_data_d    = rsp_data_q;
    ncs_d         = ncs_q;
    latch_d       = latch_q;
    wrnrd_d       = wrnrd_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (CmdValid && cmd_ready_q) begin
          wrnrd_d     = CmdWrnRd;
          addr_d      = CmdAddress;
          wdata_d     = CmdData;
          ncs_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        latch_d = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (RamBusAck) begin
          rsp_data_d    = wrnrd_q ? '0 : RamBusDataOut;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          ncs_d         = 1'b0;
          latch_d       = 1'b0;
          cnt_d         = '0;
          state_d       = RESP;
        end else if (timeout_hit) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          ncs_d         = 1'b0;
          latch_d       = 1'b0;
          cnt_d         = '0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (RspReady) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge DEVRST_N) begin
    if (!DEVRST_N) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= '0;
      ncs_q         <= 1'b0;
      latch_q       <= 1'b0;
      wrnrd_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_data_q    <= rsp_data_d;
      ncs_q         <= ncs_d;
      latch_q       <= latch_d;
      wrnrd_q       <= wrnrd_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
    end
  end

  assign CmdReady      = cmd_ready_q;
  assign RspValid      = rsp_valid_q;
  assign RspTimeout    = rsp_timeout_q;
  assign RspData       = rsp_data_q;
  assign RamBusnCs     = ncs_q;
  assign RamBusLatch   = latch_q;
  assign RamBusWrnRd   = wrnrd_q;
  assign RamBusAddress = addr_q;
  assign RamBusDataIn  = wdata_q;

endmodule
